// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART receiver:
// register offsets, STATUS bit positions and FSM encoding.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [31:0] OFF_RXDATA = 32'h0;
    localparam logic [31:0] OFF_STATUS = 32'h4;
    localparam logic [31:0] OFF_CTRL   = 32'h8;

    localparam int ST_NE   = 0;
    localparam int ST_OVR  = 1;
    localparam int ST_FERR = 2;
    localparam int ST_FULL = 3;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_START = 2'd1;
    localparam state_t S_DATA  = 2'd2;
    localparam state_t S_STOP  = 2'd3;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous byte FIFO for received characters.
// A pop in the same cycle frees a slot, so push-while-full is accepted then.
module rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? 8'd0 : mem[rd_ptr];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_slave.sv
// Memory-mapped 8N1 UART receiver with 16x oversampling,
// a small receive FIFO, sticky error flags and a level interrupt.
module uart_rx_slave
    import uart_pkg::*;
#(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          BAUD       = 9600,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0030
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        irq
);

    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int TW  = $clog2(DIV + 1);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic          rx_meta;
    logic          rx_sync;
    logic [TW-1:0] tcnt;
    logic          tick;
    state_t        state;
    logic [3:0]    scnt;
    logic [2:0]    bitn;
    logic [7:0]    shreg;

    logic          stop_smp;
    logic          push_req;
    logic          ferr_set;
    logic          ovr_set;

    logic          hit_data;
    logic          hit_stat;
    logic          hit_ctrl;
    logic          pop;
    logic          clr_ovr;
    logic          clr_ferr;

    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic          ovr;
    logic          ferr;
    logic          ien;
    logic [31:0]   status;
    logic          unused;

    assign unused = ^{wdata[31:3], fifo_count};

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign tick = (tcnt == TW'(DIV - 1));

    // Oversample tick divider, held at zero while idle to align to the start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt <= '0;
        end else if (state == S_IDLE || tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // Frame FSM: mid-bit sampling at scnt 7 for start, every 16 ticks after.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            scnt  <= '0;
            bitn  <= '0;
            shreg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rx_sync) begin
                        state <= S_START;
                        scnt  <= '0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (scnt == 4'd7) begin
                            scnt  <= '0;
                            bitn  <= '0;
                            state <= rx_sync ? S_IDLE : S_DATA;
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (scnt == 4'(OVERSAMPLE - 1)) begin
                            scnt  <= '0;
                            shreg <= {rx_sync, shreg[7:1]};
                            bitn  <= bitn + 3'd1;
                            if (bitn == 3'd7) begin
                                state <= S_STOP;
                            end
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (scnt == 4'(OVERSAMPLE - 1)) begin
                            scnt  <= '0;
                            state <= S_IDLE;
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stop_smp = (state == S_STOP) & tick & (scnt == 4'(OVERSAMPLE - 1));
    assign push_req = stop_smp & rx_sync;
    assign ferr_set = stop_smp & ~rx_sync;
    assign ovr_set  = push_req & fifo_full & ~pop;

    assign hit_data = (addr == BASE_ADDR + OFF_RXDATA);
    assign hit_stat = (addr == BASE_ADDR + OFF_STATUS);
    assign hit_ctrl = (addr == BASE_ADDR + OFF_CTRL);
    assign pop      = rd & hit_data;
    assign clr_ovr  = wr & hit_stat & wdata[ST_OVR];
    assign clr_ferr = wr & hit_stat & wdata[ST_FERR];

    rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (shreg),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky error flags and interrupt enable; a new error beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
            ien  <= 1'b0;
        end else begin
            if (ovr_set) begin
                ovr <= 1'b1;
            end else if (clr_ovr) begin
                ovr <= 1'b0;
            end
            if (ferr_set) begin
                ferr <= 1'b1;
            end else if (clr_ferr) begin
                ferr <= 1'b0;
            end
            if (wr && hit_ctrl) begin
                ien <= wdata[0];
            end
        end
    end

    // Level interrupt, registered so it trails the FIFO state by one clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= ien & ~fifo_empty;
        end
    end

    always_comb begin
        status          = '0;
        status[ST_NE]   = ~fifo_empty;
        status[ST_OVR]  = ovr;
        status[ST_FERR] = ferr;
        status[ST_FULL] = fifo_full;
    end

    // Load data mux; unmapped addresses and idle bus read as zero.
    always_comb begin
        rdata = '0;
        if (rd) begin
            case (1'b1)
                hit_data: rdata = {24'd0, fifo_dout};
                hit_stat: rdata = status;
                hit_ctrl: rdata = {31'd0, ien};
                default:  rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_slave.sv
// Scoreboard bench for uart_rx_slave: frames are driven on rx,
// expected bytes and flags are modelled and compared on bus reads.
module tb_uart_rx_slave;

    localparam logic [31:0] BASE = 32'h4000_0030;
    localparam logic [31:0] STAT = 32'h4000_0034;
    localparam logic [31:0] CTRL = 32'h4000_0038;
    localparam int          BITC = 160;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rx;
    logic        irq;

    int          cmp_n = 0;
    int          err_n = 0;
    logic [7:0]  sb[$];
    logic        m_ovr;
    logic        m_ferr;
    int          push_lat = -1;

    uart_rx_slave #(
        .CLK_HZ     (1_600_000),
        .BAUD       (10_000),
        .FIFO_DEPTH (4),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rd    (rd),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .rx    (rx),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_status();
        return {28'd0, sb.size() == 4, m_ferr, m_ovr, sb.size() != 0};
    endfunction

    function automatic logic [31:0] exp_pop();
        if (sb.size() == 0) return 32'd0;
        return {24'd0, sb.pop_front()};
    endfunction

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        rd   = 1'b1;
        addr = a;
        #1 d = rdata;
        @(negedge clk);
        rd   = 1'b0;
        addr = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        wr    = 1'b1;
        addr  = a;
        wdata = v;
        @(negedge clk);
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        if (a == STAT && v[1]) m_ovr = 1'b0;
        if (a == STAT && v[2]) m_ferr = 1'b0;
    endtask

    task automatic send_head(input logic [7:0] b);
        @(negedge clk);
        rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BITC) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_head(b);
        rx = stop;
        repeat (BITC) @(negedge clk);
        rx = 1'b1;
        if (!stop) m_ferr = 1'b1;
        else if (sb.size() < 4) sb.push_back(b);
        else m_ovr = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] e;
        reset = 1'b0;
        rd = 0; wr = 0; addr = '0; wdata = '0; rx = 1'b1;
        m_ovr = 0; m_ferr = 0;
        repeat (4) @(negedge clk);
        cmp_n++;
        if (irq !== 1'b0) begin
            err_n++; $display("FAIL rst_irq: got %b want 0", irq);
        end
        cmp_n++;
        if (rdata !== 32'd0) begin
            err_n++; $display("FAIL rst_rdata: got %h want 0", rdata);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(STAT, d);
        e = exp_status();
        cmp_n++;
        if (d !== e) begin
            err_n++; $display("FAIL rst_status: got %h want %h", d, e);
        end
        bus_read(CTRL, d);
        cmp_n++;
        if (d !== 32'd0) begin
            err_n++; $display("FAIL rst_ctrl: got %h want 0", d);
        end
    endtask

    task automatic test_single();
        logic [31:0] d;
        logic [31:0] e;
        send_frame(8'hA5, 1'b1);
        bus_read(STAT, d);
        e = exp_status();
        cmp_n++;
        if (d !== e) begin
            err_n++; $display("FAIL single_stat_pre: got %h want %h", d, e);
        end
        bus_read(BASE, d);
        e = exp_pop();
        cmp_n++;
        if (d !== e) begin
            err_n++; $display("FAIL single_data: got %h want %h", d, e);
        end
        bus_read(STAT, d);
        e = exp_status();
        cmp_n++;
        if (d !== e) begin
            err_n++; $display("FAIL single_stat_post: got %h want %h", d, e);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic [31:0] e;
        bus_write(CTRL, 32'd1);
        bus_read(CTRL, d);
        cmp_n++;
        if (d !== 32'd1) begin
            err_n++; $display("FAIL irq_ctrl: got %h want 1", d);
        end
        send_head(8'h3C);
        rx   = 1'b1;
        rd   = 1'b1;
        addr = STAT;
        for (int i = 1; i <= BITC; i++) begin
            @(negedge clk);
            if (rdata[0] === 1'b1) begin
                push_lat = i;
                break;
            end
        end
        cmp_n++;
        if (push_lat < 0) begin
            err_n++; $display("FAIL irq_push_seen: got none want push");
        end else begin
            cmp_n++;
            if (irq !== 1'b0) begin
                err_n++; $display("FAIL irq_lag_push: got %b want 0", irq);
            end
            @(negedge clk);
            cmp_n++;
            if (irq !== 1'b1) begin
                err_n++; $display("FAIL irq_set: got %b want 1", irq);
            end
        end
        rd   = 1'b0;
        addr = '0;
        sb.push_back(8'h3C);
        repeat (BITC) @(negedge clk);
        bus_read(BASE, d);
        e = exp_pop();
        cmp_n++;
        if (d !== e) begin
            err_n++; $display("FAIL irq_data: got %h want %h", d, e);
        end
        cmp_n++;
        if (irq !== 1'b1) begin
            err_n++; $display("FAIL irq_lag_pop: got %b want 1", irq);
        end
        @(negedge clk);
        cmp_n++;
        if (irq !== 1'b0) begin
            err_n++; $display("FAIL irq_clear: got %b want 0", irq);
        end
        bus_write(CTRL, 32'd0);
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        logic [31:0] e;
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        bus_read(STAT, d);
        e = exp_status();
        cmp_n++;
        if (d !== e) begin
            err_n++; $display("FAIL ovr_stat: got %h want %h", d, e);
        end
        for (int i = 0; i < 5; i++) begin
            bus_read(BASE, d);
            e = exp_pop();
            cmp_n++;
            if (d !== e) begin
                err_n++; $display("FAIL ovr_data%0d: got %h want %h", i, d, e);
            end
        end
        bus_read(STAT, d);
        e = exp_status();
        cmp_n++;
        if (d !== e) begin
            err_n++; $display("FAIL ovr_stat_drained: got %h want %h", d, e);
        end
        bus_write(STAT, 32'h2);
        bus_read(STAT, d);
        e = exp_status();
        cmp_n++;
        if (d !== e) begin
            err_n++; $display("FAIL ovr_w1c: got %h want %h", d, e);
        end
    endtask

    task automatic test_frame_err();
        logic [31:0] d;
        logic [31:0] e;
        send_frame(8'h55, 1'b0);
        repeat (BITC) @(negedge clk);
        bus_read(STAT, d);
        e = exp_status();
        cmp_n++;
        if (d !== e) begin
            err_n++; $display("FAIL ferr_stat: got %h want %h", d, e);
        end
        bus_read(BASE, d);
        e = exp_pop();
        cmp_n++;
        if (d !== e) begin
            err_n++; $display("FAIL ferr_data: got %h want %h", d, e);
        end
        bus_write(STAT, 32'h4);
        bus_read(STAT, d);
        e = exp_status();
        cmp_n++;
        if (d !== e) begin
            err_n++; $display("FAIL ferr_w1c: got %h want %h", d, e);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic [31:0] e;
        @(negedge clk);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BITC) @(negedge clk);
        bus_read(STAT, d);
        e = exp_status();
        cmp_n++;
        if (d !== e) begin
            err_n++; $display("FAIL glitch_stat: got %h want %h", d, e);
        end
        bus_read(BASE, d);
        e = exp_pop();
        cmp_n++;
        if (d !== e) begin
            err_n++; $display("FAIL glitch_data: got %h want %h", d, e);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic [31:0] e;
        @(negedge clk);
        rx = 1'b0;
        repeat (BITC) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BITC + 40) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        repeat (BITC) @(negedge clk);
        send_frame(8'h81, 1'b1);
        bus_read(STAT, d);
        e = exp_status();
        cmp_n++;
        if (d !== e) begin
            err_n++; $display("FAIL mid_stat: got %h want %h", d, e);
        end
        for (int i = 0; i < 2; i++) begin
            bus_read(BASE, d);
            e = exp_pop();
            cmp_n++;
            if (d !== e) begin
                err_n++; $display("FAIL mid_data%0d: got %h want %h", i, d, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] e;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        bus_read(STAT, d);
        e = exp_status();
        cmp_n++;
        if (d !== e) begin
            err_n++; $display("FAIL b2b_full: got %h want %h", d, e);
        end
        if (push_lat > 1) begin
            send_head(8'h55);
            rx = 1'b1;
            repeat (push_lat - 1) @(negedge clk);
            rd   = 1'b1;
            addr = BASE;
            #1 d = rdata;
            @(negedge clk);
            rd   = 1'b0;
            addr = '0;
            e = exp_pop();
            sb.push_back(8'h55);
            cmp_n++;
            if (d !== e) begin
                err_n++; $display("FAIL b2b_pop: got %h want %h", d, e);
            end
            repeat (BITC) @(negedge clk);
            bus_read(STAT, d);
            e = exp_status();
            cmp_n++;
            if (d !== e) begin
                err_n++; $display("FAIL b2b_stat: got %h want %h", d, e);
            end
            for (int i = 0; i < 4; i++) begin
                bus_read(BASE, d);
                e = exp_pop();
                cmp_n++;
                if (d !== e) begin
                    err_n++; $display("FAIL b2b_data%0d: got %h want %h", i, d, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_irq();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
